ebi_slave_frontend: RTL and testbench

- Bus-interface stage between the raw GPIO pads of the ARM asynchronous parallel bus (CE/WE/OE strobes, 16-bit data) and the FPGA core logic.
- Synchronises and glitch-filters the active-low strobes, tracks the bus cycle with an FSM, and hands the core clean single-cycle write and read-request pulses.
- Controls the data-bus tristate direction, including a turnaround guard.
- Downstream logic, such as the register/display block, never touches raw strobes.

---
 rtl/ebi_pkg.sv | 22 ++
 rtl/ebi_slave_frontend_strobe_sync_filter.sv | 55 +++++
 rtl/ebi_slave_frontend.sv | 141 ++++++++++++++
 tb/tb_ebi_slave_frontend.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ebi_pkg.sv
// Shared types and default sizing for the EBI slave front end.
package ebi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } ebi_state_t;

  localparam int EBI_DW          = 16;
  localparam int EBI_SYNC_STAGES = 2;
  localparam int EBI_FILT_LEN    = 3;
  localparam int EBI_TURN_CYCLES = 2;

  // strobe bundle layout inside the front end
  localparam int NUM_STRB = 3;
  localparam int S_CE     = 0;
  localparam int S_WE     = 1;
  localparam int S_OE     = 2;

endpackage

// File: rtl/ebi_slave_frontend_strobe_sync_filter.sv
// One active-low strobe: metastability synchroniser followed by a
// run-length glitch filter. rise/fall pulse together with the filt_n change.
module strobe_sync_filter
  import ebi_pkg::*;
#(
  parameter int SYNC_STAGES = EBI_SYNC_STAGES,
  parameter int FILT_LEN    = EBI_FILT_LEN
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic filt_n,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   smp;

  assign smp = sync_q[SYNC_STAGES-1];

  // shift the raw pad level through the synchroniser chain (idles high)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_n};
  end

  // change the filtered level only after FILT_LEN differing samples in a row
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      filt_n <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (smp == filt_n) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        filt_n <= smp;
        rise   <= smp;
        fall   <= ~smp;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ebi_slave_frontend.sv
// Front end between the raw asynchronous parallel-bus pads and core logic:
// filtered strobes, bus-cycle FSM, single-cycle write/read pulses and
// tristate control with a turnaround guard after reads.
module ebi_slave_frontend
  import ebi_pkg::*;
#(
  parameter int DW          = EBI_DW,
  parameter int SYNC_STAGES = EBI_SYNC_STAGES,
  parameter int FILT_LEN    = EBI_FILT_LEN,
  parameter int TURN_CYCLES = EBI_TURN_CYCLES
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce_n,
  input  logic          we_n,
  input  logic          oe_n,
  input  logic [DW-1:0] pad_din,
  output logic [DW-1:0] pad_dout,
  output logic          data_oe,
  output logic          wr_valid,
  output logic [DW-1:0] wr_data,
  output logic          rd_req,
  input  logic [DW-1:0] rd_data,
  output logic          bus_err
);

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

  logic [NUM_STRB-1:0] raw_v, filt_v, rise_v, fall_v;
  ebi_state_t          state, state_nxt;
  logic [TW-1:0]       turn_cnt, turn_cnt_nxt;
  logic                oe_en, conf_q, conflict;
  logic                wr_fire, err_nxt, load_rd;
  logic [DW-1:0]       d_q, d_hold;

  assign raw_v = {oe_n, we_n, ce_n};

  generate
    for (genvar i = 0; i < NUM_STRB; i++) begin : g_strb
      strobe_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
      ) u_strb (
        .clock (clock),
        .reset (reset),
        .raw_n (raw_v[i]),
        .filt_n(filt_v[i]),
        .rise  (rise_v[i]),
        .fall  (fall_v[i])
      );
    end
  endgenerate

  assign conflict = (filt_v == '0);

  // bus is released in the very cycle a read-ending edge is seen
  assign data_oe = oe_en & (state == READ) & ~rise_v[S_OE] & ~rise_v[S_CE];

  // next-state and pulse decode; rd_req is issued on the IDLE->READ decision
  always_comb begin
    state_nxt    = state;
    turn_cnt_nxt = turn_cnt;
    wr_fire      = 1'b0;
    err_nxt      = 1'b0;
    load_rd      = 1'b0;
    rd_req       = 1'b0;
    case (state)
      IDLE: begin
        if (conflict) begin
          // report a conflict once, not every cycle it persists
          err_nxt = ~conf_q | (|fall_v);
        end else if (~filt_v[S_CE] & ~filt_v[S_WE]) begin
          state_nxt = WRITE;
        end else if (~filt_v[S_CE] & ~filt_v[S_OE] & ~wr_valid) begin
          state_nxt = READ;
          rd_req    = 1'b1;
        end
      end
      WRITE: begin
        if (rise_v[S_WE]) begin
          wr_fire   = 1'b1;
          state_nxt = IDLE;
        end else if (rise_v[S_CE]) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (fall_v[S_OE]) begin
          err_nxt = 1'b1;
        end
      end
      READ: begin
        if (rise_v[S_OE] | rise_v[S_CE]) begin
          state_nxt    = TURN;
          turn_cnt_nxt = '0;
        end else if (~oe_en) begin
          load_rd = 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) state_nxt = IDLE;
        else                       turn_cnt_nxt = turn_cnt + TW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, turnaround counter and conflict-seen flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      turn_cnt <= '0;
      conf_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_cnt_nxt;
      conf_q   <= (state == IDLE) & conflict;
    end
  end

  // data capture, write/read data registers and registered pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_q      <= '0;
      d_hold   <= '0;
      wr_valid <= 1'b0;
      wr_data  <= '0;
      bus_err  <= 1'b0;
      pad_dout <= '0;
      oe_en    <= 1'b0;
    end else begin
      d_q      <= pad_din;
      wr_valid <= wr_fire;
      bus_err  <= err_nxt;
      oe_en    <= (state_nxt == READ) & (oe_en | load_rd);
      if ((state == WRITE) && !filt_v[S_WE]) d_hold <= d_q;
      if (wr_fire) wr_data <= d_hold;
      if (load_rd) pad_dout <= rd_data;
    end
  end

endmodule

// File: tb/tb_ebi_slave_frontend.sv
// Directed bench for ebi_slave_frontend: write, glitch, read, abort,
// conflict and reset-during-read scenarios with hand-derived timing.
module tb_ebi_slave_frontend;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce_n = 1'b1, we_n = 1'b1, oe_n = 1'b1;
  logic [15:0] pad_din = 16'h0000;
  logic [15:0] pad_dout, wr_data;
  logic [15:0] rd_data = 16'hDEAD;
  logic        data_oe, wr_valid, rd_req, bus_err;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clock = ~clock;

  ebi_slave_frontend #(
    .DW(16), .SYNC_STAGES(2), .FILT_LEN(3), .TURN_CYCLES(2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .ce_n    (ce_n),
    .we_n    (we_n),
    .oe_n    (oe_n),
    .pad_din (pad_din),
    .pad_dout(pad_dout),
    .data_oe (data_oe),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .rd_req  (rd_req),
    .rd_data (rd_data),
    .bus_err (bus_err)
  );

  // core model: registered answer the cycle after a read request
  always @(posedge clock) rd_data <= rd_req ? 16'h1234 : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    int nwv, nerr, nrq, noe, at, at2;

    // reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_dout", pad_dout, 16'h0000);
    chk("rst_oe", data_oe, 1'b0);
    chk("rst_wv", wr_valid, 1'b0);
    chk("rst_wd", wr_data, 16'h0000);
    chk("rst_rq", rd_req, 1'b0);
    chk("rst_err", bus_err, 1'b0);
    repeat (5) tick();

    // write: ce/we low 10 cycles, both released together; write wins
    ce_n = 1'b0; we_n = 1'b0; pad_din = 16'hBEEF;
    repeat (10) tick();
    ce_n = 1'b1; we_n = 1'b1;
    nwv = 0; nerr = 0; at = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (wr_valid) begin
        nwv++;
        if (at == 0) at = i;
        chk("wr_data", wr_data, 16'hBEEF);
      end
      if (bus_err) nerr++;
    end
    chk("wr_cnt", nwv, 1);
    chk("wr_lat", at, 6);
    chk("wr_err", nerr, 0);
    pad_din = 16'h1111;
    tick();
    chk("wr_hold", wr_data, 16'hBEEF);

    // glitch: we low for 2 cycles only under a held ce
    ce_n = 1'b0;
    repeat (8) tick();
    we_n = 1'b0;
    repeat (2) tick();
    we_n = 1'b1;
    nwv = 0; nerr = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (wr_valid) nwv++;
      if (bus_err) nerr++;
      if (i == 10) ce_n = 1'b1;
    end
    chk("gl_wr", nwv, 0);
    chk("gl_err", nerr, 0);
    chk("gl_wd", wr_data, 16'hBEEF);

    // read: ce/oe low 12 cycles
    ce_n = 1'b0; oe_n = 1'b0;
    nrq = 0; noe = 0; at = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (rd_req) begin
        nrq++;
        if (at == 0) at = i;
      end
      if (data_oe) noe++;
      if (i == 7 || i == 16) begin
        chk("rd_oe_hi", data_oe, 1'b1);
        chk("rd_dout", pad_dout, 16'h1234);
      end
      if (i == 6 || i == 17 || i == 18 || i == 19) chk("rd_oe_lo", data_oe, 1'b0);
      if (i == 12) begin ce_n = 1'b1; oe_n = 1'b1; end
    end
    chk("rd_cnt", nrq, 1);
    chk("rd_lat", at, 5);
    chk("rd_oe_len", noe, 10);

    // abort: ce released 5 cycles before we
    pad_din = 16'hAAAA;
    ce_n = 1'b0; we_n = 1'b0;
    nwv = 0; nerr = 0; at = 0;
    for (int i = 1; i <= 28; i++) begin
      tick();
      if (wr_valid) nwv++;
      if (bus_err) begin
        nerr++;
        if (at == 0) at = i;
      end
      if (i == 10) ce_n = 1'b1;
      if (i == 15) we_n = 1'b1;
    end
    chk("ab_err", nerr, 1);
    chk("ab_at", at, 16);
    chk("ab_wr", nwv, 0);
    chk("ab_wd", wr_data, 16'hBEEF);

    // conflict: all three strobes low together
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
    nerr = 0; at = 0; noe = 0; nrq = 0; nwv = 0;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (bus_err) begin
        nerr++;
        if (at == 0) at = i;
      end
      if (data_oe) noe++;
      if (rd_req) nrq++;
      if (wr_valid) nwv++;
      if (i == 8) begin ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; end
    end
    chk("cf_err", nerr, 1);
    chk("cf_at", at, 6);
    chk("cf_oe", noe, 0);
    chk("cf_rq", nrq, 0);
    chk("cf_wv", nwv, 0);

    // reset in the middle of a driven read, strobes kept low
    ce_n = 1'b0; oe_n = 1'b0;
    repeat (10) tick();
    chk("mr_oe_pre", data_oe, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mr_oe", data_oe, 1'b0);
    chk("mr_dout", pad_dout, 16'h0000);
    repeat (2) tick();
    reset = 1'b0;
    nrq = 0; at = 0; at2 = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (rd_req) begin
        nrq++;
        if (at == 0) at = i;
      end
      if (data_oe && at2 == 0) at2 = i;
      if (i == 7) chk("mr_dout2", pad_dout, 16'h1234);
    end
    chk("mr_rq", nrq, 1);
    chk("mr_at", at, 5);
    chk("mr_oe_at", at2, 7);
    ce_n = 1'b1; oe_n = 1'b1;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
